bus_dma_arbiter: RTL and testbench

Owns the single CPU-cycle memory bus and shares it between the CPU core and an OAM-style sprite DMA engine. In IDLE the CPU bus passes straight through to memory. A CPU write of page P to DMA_TRIGGER_ADDR stalls the CPU, then copies DMA_LENGTH bytes from {P,8'h00} upward to DMA_TARGET_ADDR, then releases the CPU. Sits between the CPU core and the system address decoder.

---
 rtl/bus_pkg.sv | 16 +
 rtl/bus_dma_arbiter.sv | 148 ++++++++++++++
 tb/tb_bus_dma_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and default constants for the CPU/DMA bus arbiter.
package bus_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } dma_state_e;

  localparam logic [15:0] DMA_TRIGGER_ADDR_DEFAULT = 16'h4014;
  localparam logic [15:0] DMA_TARGET_ADDR_DEFAULT  = 16'h2004;
  localparam int unsigned DMA_LENGTH_DEFAULT       = 256;

endpackage

// File: rtl/bus_dma_arbiter.sv
// Shares the CPU memory bus between the CPU core and a sprite DMA engine.
// IDLE passes the CPU bus straight through; a write of page P to the trigger
// address stalls the CPU and copies DMA_LENGTH bytes from {P,00} to the
// target address, one read and one write bus cycle per byte.
// Optional: `define DMA_ODD_CYCLE_ALIGN_EN inserts one ALIGN dead cycle when
// the DMA is triggered on an odd-parity tick.
module bus_dma_arbiter
  import bus_pkg::*;
#(
  parameter logic [15:0] DMA_TRIGGER_ADDR = DMA_TRIGGER_ADDR_DEFAULT,
  parameter logic [15:0] DMA_TARGET_ADDR  = DMA_TARGET_ADDR_DEFAULT,
  parameter int unsigned DMA_LENGTH       = DMA_LENGTH_DEFAULT
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        cycle_tick_i,
  input  logic [15:0] cpu_address_i,
  input  logic        cpu_address_valid_i,
  input  logic [7:0]  cpu_data_i,
  input  logic        cpu_data_valid_i,
  output logic [7:0]  cpu_data_o,
  output logic        cpu_data_valid_o,
  output logic        cpu_stall_o,
  output logic [15:0] mem_address_o,
  output logic        mem_address_valid_o,
  output logic [7:0]  mem_data_o,
  output logic        mem_write_o,
  input  logic [7:0]  mem_data_i,
  input  logic        mem_data_valid_i
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LENGTH - 1);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic       stall_q, stall_d;
  logic       trigger;

`ifdef DMA_ODD_CYCLE_ALIGN_EN
  logic parity_q, parity_d;
  logic align_q, align_d;
`endif

  // State register: reset wins over everything, otherwise advance only on a tick.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      page_q   <= '0;
      idx_q    <= '0;
      data_q   <= '0;
      stall_q  <= 1'b0;
`ifdef DMA_ODD_CYCLE_ALIGN_EN
      parity_q <= 1'b0;
      align_q  <= 1'b0;
`endif
    end else if (cycle_tick_i) begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      stall_q  <= stall_d;
`ifdef DMA_ODD_CYCLE_ALIGN_EN
      parity_q <= parity_d;
      align_q  <= align_d;
`endif
    end
  end

  // Next-state logic plus the bus mux: passthrough in IDLE, DMA-driven otherwise.
  always_comb begin
    state_d             = state_q;
    page_d              = page_q;
    idx_d               = idx_q;
    data_d              = data_q;
    mem_address_o       = '0;
    mem_address_valid_o = 1'b0;
    mem_data_o          = '0;
    mem_write_o         = 1'b0;
    cpu_data_o          = '0;
    cpu_data_valid_o    = 1'b0;
    trigger             = cpu_address_valid_i & cpu_data_valid_i &
                          (cpu_address_i == DMA_TRIGGER_ADDR);
`ifdef DMA_ODD_CYCLE_ALIGN_EN
    parity_d            = ~parity_q;
    align_d             = align_q;
`endif

    unique case (state_q)
      IDLE: begin
        mem_address_o       = cpu_address_i;
        mem_address_valid_o = cpu_address_valid_i;
        mem_data_o          = cpu_data_i;
        mem_write_o         = cpu_data_valid_i;
        cpu_data_o          = mem_data_i;
        cpu_data_valid_o    = mem_data_valid_i;
        if (trigger) begin
          page_d  = cpu_data_i;
          idx_d   = '0;
          state_d = HALT;
`ifdef DMA_ODD_CYCLE_ALIGN_EN
          // Remember the parity of the tick on which HALT is entered.
          align_d = parity_q;
`endif
        end
      end
      HALT: begin
        state_d = READ;
`ifdef DMA_ODD_CYCLE_ALIGN_EN
        if (align_q) state_d = ALIGN;
`endif
      end
      ALIGN: begin
        state_d = READ;
      end
      READ: begin
        // Low byte is the index itself, so it never carries into the page.
        mem_address_o       = {page_q, idx_q};
        mem_address_valid_o = 1'b1;
        if (mem_data_valid_i) begin
          data_d  = mem_data_i;
          state_d = WRITE;
        end
      end
      WRITE: begin
        mem_address_o       = DMA_TARGET_ADDR;
        mem_address_valid_o = 1'b1;
        mem_data_o          = data_q;
        mem_write_o         = 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = READ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    stall_d = (state_d != IDLE);
  end

  assign cpu_stall_o = stall_q;

endmodule

// File: tb/tb_bus_dma_arbiter.sv
// Directed bench for bus_dma_arbiter: passthrough vector table, then full DMA,
// wait-state, retrigger, parity and mid-DMA reset sequences.
// Honours `define DMA_ODD_CYCLE_ALIGN_EN for the expected stall length.
module tb_bus_dma_arbiter;
  import bus_pkg::*;

  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] TGT  = 16'h2004;
  localparam int unsigned LEN  = 256;

  logic        clock_i = 1'b0;
  logic        reset_i;
  logic        cycle_tick_i;
  logic [15:0] cpu_address_i;
  logic        cpu_address_valid_i;
  logic [7:0]  cpu_data_i;
  logic        cpu_data_valid_i;
  logic [7:0]  cpu_data_o;
  logic        cpu_data_valid_o;
  logic        cpu_stall_o;
  logic [15:0] mem_address_o;
  logic        mem_address_valid_o;
  logic [7:0]  mem_data_o;
  logic        mem_write_o;
  logic [7:0]  mem_data_i;
  logic        mem_data_valid_i;

  bus_dma_arbiter #(
    .DMA_TRIGGER_ADDR (TRIG),
    .DMA_TARGET_ADDR  (TGT),
    .DMA_LENGTH       (LEN)
  ) dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .cycle_tick_i        (cycle_tick_i),
    .cpu_address_i       (cpu_address_i),
    .cpu_address_valid_i (cpu_address_valid_i),
    .cpu_data_i          (cpu_data_i),
    .cpu_data_valid_i    (cpu_data_valid_i),
    .cpu_data_o          (cpu_data_o),
    .cpu_data_valid_o    (cpu_data_valid_o),
    .cpu_stall_o         (cpu_stall_o),
    .mem_address_o       (mem_address_o),
    .mem_address_valid_o (mem_address_valid_o),
    .mem_data_o          (mem_data_o),
    .mem_write_o         (mem_write_o),
    .mem_data_i          (mem_data_i),
    .mem_data_valid_i    (mem_data_valid_i)
  );

  always #5 clock_i = ~clock_i;

  // Memory model: RAM[a] = a[7:0] ^ FF, optional wait states on one address.
  logic [7:0]  ram [0:65535];
  logic        model_en;
  logic [7:0]  tb_mem_data;
  logic        tb_mem_valid;
  logic [15:0] wait_addr;
  int unsigned wait_left;

  always_comb begin
    if (model_en) begin
      mem_data_i       = ram[mem_address_o];
      mem_data_valid_i = mem_address_valid_o && !mem_write_o &&
                         !(mem_address_o == wait_addr && wait_left != 0);
    end else begin
      mem_data_i       = tb_mem_data;
      mem_data_valid_i = tb_mem_valid;
    end
  end

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned stall_ticks;
  int unsigned wait_reads;
  int unsigned bad_cpu;
  int unsigned tick_count;
  logic        was_wait;
  logic [7:0]  wr_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic cpu_drive(input logic [15:0] a, input logic av, input logic [7:0] d, input logic dv);
    cpu_address_i       = a;
    cpu_address_valid_i = av;
    cpu_data_i          = d;
    cpu_data_valid_i    = dv;
  endtask

  // Observe the bus just before the tick edge.
  task automatic sample();
    if (cpu_stall_o) begin
      stall_ticks++;
      if (cpu_data_valid_o || cpu_data_o != 8'h00) bad_cpu++;
    end
    if (mem_write_o && mem_address_valid_o && mem_address_o == TGT) wr_q.push_back(mem_data_o);
    if (cpu_stall_o && mem_address_valid_o && !mem_write_o && mem_address_o == wait_addr) wait_reads++;
    was_wait = model_en && wait_left != 0 && mem_address_valid_o && !mem_write_o &&
               mem_address_o == wait_addr;
  endtask

  // One bus tick followed by one clock without a tick; returns on a negedge.
  task automatic tick();
    #2;
    sample();
    cycle_tick_i = 1'b1;
    @(posedge clock_i);
    #1;
    cycle_tick_i = 1'b0;
    tick_count++;
    if (was_wait) wait_left--;
    @(negedge clock_i);
    @(posedge clock_i);
    @(negedge clock_i);
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    cpu_drive(16'h0000, 1'b0, 8'h00, 1'b0);
    wait_left = 0;
    @(posedge clock_i);
    @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    @(negedge clock_i);
    tick_count = 0;
  endtask

  task automatic passthrough_read_check(input string name);
    cpu_drive(16'h0010, 1'b1, 8'h00, 1'b0);
    #1;
    check({name, "_addr"}, 64'(mem_address_o), 64'h0010);
    check({name, "_data"}, {55'd0, cpu_data_valid_o, cpu_data_o}, {55'd0, 1'b1, 8'hEF});
  endtask

  task automatic run_dma(input logic [7:0] page, input int unsigned wait_n,
                         input bit retrig, input int abort_at);
    int unsigned exp_stall;
    int unsigned bad;
    bit          aborted;
    bit          odd;
    stall_ticks = 0;
    wait_reads  = 0;
    bad_cpu     = 0;
    aborted     = 1'b0;
    wr_q.delete();
    model_en    = 1'b1;
    wait_addr   = {page, 8'h05};
    wait_left   = wait_n;
    odd         = tick_count[0];
    exp_stall   = 1 + 2 * LEN + wait_n;
`ifdef DMA_ODD_CYCLE_ALIGN_EN
    if (odd) exp_stall++;
`endif
    cpu_drive(TRIG, 1'b1, page, 1'b1);
    #1;
    check("trigger_passthrough", {mem_address_o, mem_address_valid_o, mem_write_o, mem_data_o},
          {TRIG, 1'b1, 1'b1, page});
    tick();
    for (int n = 0; n < 3000; n++) begin
      if (!cpu_stall_o) break;
      if (abort_at >= 0 && wr_q.size() == abort_at) begin
        aborted = 1'b1;
        break;
      end
      if (retrig) cpu_drive(TRIG, 1'b1, 8'h33, 1'b1);
      else        cpu_drive(16'h0000, 1'b0, 8'h00, 1'b0);
      tick();
    end
    cpu_drive(16'h0000, 1'b0, 8'h00, 1'b0);
    if (aborted) begin
      reset_i = 1'b1;
      @(posedge clock_i);
      #1;
      reset_i = 1'b0;
      tick_count = 0;
      @(negedge clock_i);
      check("abort_stall", 64'(cpu_stall_o), 64'd0);
      passthrough_read_check("abort_pass");
      for (int n = 0; n < 20; n++) tick();
      check("abort_writes", 64'(wr_q.size()), 64'(abort_at));
    end else begin
      check("dma_timeout", 64'(cpu_stall_o), 64'd0);
      check("stall_ticks", 64'(stall_ticks), 64'(exp_stall));
      check("write_count", 64'(wr_q.size()), 64'(LEN));
      bad = 0;
      for (int i = 0; i < wr_q.size() && i < LEN; i++)
        if (wr_q[i] !== (8'(i) ^ 8'hFF)) bad++;
      check("write_data", 64'(bad), 64'd0);
      if (wr_q.size() == LEN) begin
        check("first_byte", 64'(wr_q[0]), 64'hFF);
        check("last_byte", 64'(wr_q[LEN-1]), 64'h00);
      end
      check("cpu_quiet_in_dma", 64'(bad_cpu), 64'd0);
      if (wait_n != 0) check("wait_reissue", 64'(wait_reads), 64'(1 + wait_n));
      passthrough_read_check("release_pass");
    end
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        av;
    logic [7:0]  d;
    logic        dv;
    logic [7:0]  md;
    logic        mv;
    logic [35:0] exp; // {mem_addr, mem_av, mem_data, mem_we, cpu_data, cpu_dv, stall}
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{16'h0010, 1'b1, 8'h00, 1'b0, 8'h5A, 1'b1, {16'h0010, 1'b1, 8'h00, 1'b0, 8'h5A, 1'b1, 1'b0}};
    vecs[1] = '{16'h1234, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, {16'h1234, 1'b1, 8'hA5, 1'b1, 8'h00, 1'b0, 1'b0}};
    vecs[2] = '{16'h4014, 1'b1, 8'h00, 1'b0, 8'h3C, 1'b1, {16'h4014, 1'b1, 8'h00, 1'b0, 8'h3C, 1'b1, 1'b0}};
    vecs[3] = '{16'h4014, 1'b0, 8'h02, 1'b1, 8'h00, 1'b0, {16'h4014, 1'b0, 8'h02, 1'b1, 8'h00, 1'b0, 1'b0}};
    vecs[4] = '{16'h4015, 1'b1, 8'h07, 1'b1, 8'h11, 1'b0, {16'h4015, 1'b1, 8'h07, 1'b1, 8'h11, 1'b0, 1'b0}};
    vecs[5] = '{16'hFFFF, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b1, {16'hFFFF, 1'b1, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0}};

    for (int unsigned a = 0; a < 65536; a++) ram[a] = 8'(a) ^ 8'hFF;
    cycle_tick_i = 1'b0;
    model_en     = 1'b0;
    tb_mem_data  = 8'h00;
    tb_mem_valid = 1'b0;
    wait_addr    = 16'h0000;
    wait_left    = 0;
    tick_count   = 0;
    was_wait     = 1'b0;

    do_reset();
    #1;
    check("reset_state", {mem_address_o, mem_address_valid_o, mem_data_o, mem_write_o,
                          cpu_data_o, cpu_data_valid_o, cpu_stall_o}, 36'd0);

    for (int i = 0; i < 6; i++) begin
      cpu_drive(vecs[i].addr, vecs[i].av, vecs[i].d, vecs[i].dv);
      tb_mem_data  = vecs[i].md;
      tb_mem_valid = vecs[i].mv;
      #1;
      check($sformatf("pass_vec%0d", i),
            {mem_address_o, mem_address_valid_o, mem_data_o, mem_write_o,
             cpu_data_o, cpu_data_valid_o, cpu_stall_o}, vecs[i].exp);
      tick();
    end
    cpu_drive(16'h0000, 1'b0, 8'h00, 1'b0);
    check("no_false_trigger", 64'(cpu_stall_o), 64'd0);

    // Full DMA (even parity), wait states, retrigger, odd parity, abort.
    do_reset();
    run_dma(8'h02, 0, 1'b0, -1);
    do_reset();
    run_dma(8'h02, 3, 1'b0, -1);
    do_reset();
    run_dma(8'h02, 0, 1'b1, -1);
    do_reset();
    tick();
    run_dma(8'h07, 0, 1'b0, -1);
    do_reset();
    run_dma(8'h03, 0, 1'b0, 100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
